fb_rc_adder: RTL and testbench

//   Registered N-bit (default 4) ripple-carry adder: S/Carry = A + B + C.

---
 rtl/fb_rc_adder_pkg.sv | 7 +
 rtl/full_adder.sv | 17 +
 rtl/fb_rc_adder.sv | 43 ++++
 tb/tb_fb_rc_adder.sv | 113 +++++++++++
 4 files changed

// File: rtl/fb_rc_adder_pkg.sv
// Shared constants for the registered ripple-carry adder.
// The top keeps WIDTH as a module parameter; this only supplies its default.
package fb_rc_adder_pkg;

  localparam int unsigned FB_RC_DEFAULT_WIDTH = 32'd4;

endpackage : fb_rc_adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell, the repeated stage of the ripple-carry chain.
// Purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop_s;

  assign prop_s = a ^ b;
  assign s      = prop_s ^ cin;
  assign cout   = (a & b) | (cin & prop_s);

endmodule : full_adder

// File: rtl/fb_rc_adder.sv
// Registered WIDTH-bit ripple-carry adder: {Carry,S} <= A + B + C, one cycle latency.
// Sum and carry are produced by a chain of full_adder cells and captured in one register stage.
module fb_rc_adder
  import fb_rc_adder_pkg::*;
#(
  parameter int WIDTH = FB_RC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] S,
  output logic             Carry
);

  logic [WIDTH:0]   c_s;
  logic [WIDTH-1:0] sum_s;

  assign c_s[0] = C;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c_s[i]),
      .s    (sum_s[i]),
      .cout (c_s[i+1])
    );
  end

  // Output register: reset clears everything, otherwise capture the chain result.
  always_ff @(posedge clk) begin
    if (rst) begin
      S     <= {WIDTH{1'b0}};
      Carry <= 1'b0;
    end else begin
      S     <= sum_s;
      Carry <= c_s[WIDTH];
    end
  end

endmodule : fb_rc_adder

// File: tb/tb_fb_rc_adder.sv
// Self-checking bench for fb_rc_adder: arithmetic reference model compared every cycle,
// plus hand-computed literal checks on directed vectors.
module tb_fb_rc_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic [W-1:0] s_out;
  logic         carry_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W:0] exp_m;
  logic       exp_valid = 1'b0;

  fb_rc_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .A     (a_in),
    .B     (b_in),
    .C     (c_in),
    .S     (s_out),
    .Carry (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the output register must hold after each edge.
  always @(posedge clk) begin
    if (rst) exp_m <= '0;
    else     exp_m <= (W+1)'(int'(a_in) + int'(b_in) + int'(c_in));
    exp_valid <= 1'b1;
  end

  // Compare DUT against the model on every falling edge once the model is primed.
  always @(negedge clk) begin
    if (exp_valid) begin
      n_cmp++;
      if ({carry_out, s_out} !== exp_m) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t A=%h B=%h C=%b rst=%b got {Carry,S}=%h want %h",
                 $time, a_in, b_in, c_in, rst, {carry_out, s_out}, exp_m);
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic r);
    a_in = a; b_in = b; c_in = c; rst = r;
  endtask

  // Drive one vector, wait one edge, check DUT and the model against a literal.
  task automatic apply_chk(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic r, input logic [W:0] lit);
    drive(a, b, c, r);
    @(posedge clk);
    #3;
    n_cmp++;
    if ({carry_out, s_out} !== lit) begin
      n_fail++;
      $display("FAIL %s dut got %h want %h", name, {carry_out, s_out}, lit);
    end
    n_cmp++;
    if (exp_m !== lit) begin
      n_fail++;
      $display("FAIL %s_model got %h want %h", name, exp_m, lit);
    end
  endtask

  initial begin
    drive(4'hA, 4'h5, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    apply_chk("reset_1", 4'hA, 4'h5, 1'b1, 1'b1, 5'h00);
    apply_chk("reset_2", 4'hA, 4'h5, 1'b1, 1'b1, 5'h00);
    apply_chk("simple",  4'h0, 4'h5, 1'b0, 1'b0, 5'h05);
    apply_chk("wrap",    4'hF, 4'h1, 1'b0, 1'b0, 5'h10);
    apply_chk("max",     4'hF, 4'hF, 1'b1, 1'b0, 5'h1F);
    apply_chk("ripple",  4'h7, 4'h8, 1'b1, 1'b0, 5'h10);
    apply_chk("no_cout", 4'h3, 4'h4, 1'b1, 1'b0, 5'h08);
    apply_chk("mid_rst", 4'h9, 4'h9, 1'b1, 1'b1, 5'h00);
    apply_chk("post_rst",4'h9, 4'h9, 1'b1, 1'b0, 5'h13);
    apply_chk("zero",    4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
    apply_chk("cin_only",4'h0, 4'h0, 1'b1, 1'b0, 5'h01);

    // Exhaustive sweep, one new vector every cycle.
    for (int i = 0; i < 512; i++) begin
      drive(W'(i >> 5), W'(i >> 1), i[0], 1'b0);
      @(posedge clk);
      #2;
    end

    // Randomized back-to-back stream with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));
      @(posedge clk);
      #2;
    end

    drive(4'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fb_rc_adder
